// File: rtl/fp_mult_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : fp_mult_pipe_if
// Brief    : Operand/result valid-ready bundle for the pipelined FP multiplier.
// Revision : 1.0 - initial release
// ============================================================================
interface fp_mult_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7,
    parameter int TAG_W = 4
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_p;
    logic [TAG_W-1:0] out_tag;
    logic [2:0]       out_flags;

    modport slave (
        input  in_valid, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_p, out_tag, out_flags
    );

    modport master (
        output in_valid, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_p, out_tag, out_flags
    );
endinterface
`default_nettype wire

// File: rtl/fp_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fp_mult_pipe
// Brief    : 3-stage valid/ready floating-point multiplier, RNE, exception flags.
//            Define FP_MULT_DENORM_EN for gradual underflow; otherwise flush-to-zero.
// Revision : 1.0 - initial release
// ============================================================================
module fp_mult_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7,
    parameter int TAG_W = 4
) (
    input wire          clk,
    input wire          rst,
    fp_mult_pipe_if.slave bus
);
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int P     = 2 * MAN_W + 2;
    localparam int EW    = EXP_W + 2;
    localparam int XW    = P + MAN_W + 3;
    localparam int BIAS  = 2 ** (EXP_W - 1) - 1;
    localparam logic signed [EW-1:0] EXP_MAX = EW'(2 ** EXP_W - 1);
    localparam logic signed [EW-1:0] EXP_ZERO = '0;

    localparam logic [1:0] K_NORM = 2'd0;
    localparam logic [1:0] K_NAN  = 2'd1;
    localparam logic [1:0] K_ZERO = 2'd2;
    localparam logic [1:0] K_INF  = 2'd3;

    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // ------------------------------------------------------------------ control
    logic v1, v2, v3;
    logic ready1, ready2, ready3;

    assign ready3       = !v3 || bus.out_ready;
    assign ready2       = !v2 || ready3;
    assign ready1       = !v1 || ready2;
    assign bus.in_ready = ready1;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            if (ready1) v1 <= bus.in_valid;
            if (ready2) v2 <= v1;
            if (ready3) v3 <= v2;
        end
    end

    // ------------------------------------------------------------------ stage 1
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb, eaf, ebf;
    logic [MAN_W-1:0] fa, fb;
    logic [MAN_W:0]   ma, mb;
    logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [1:0]       kind_c;
    logic             inv_c;

    assign {sa, ea, fa} = bus.in_a;
    assign {sb, eb, fb} = bus.in_b;
    assign a_nan = (&ea) && (|fa);
    assign b_nan = (&eb) && (|fb);
    assign a_inf = (&ea) && !(|fa);
    assign b_inf = (&eb) && !(|fb);

`ifdef FP_MULT_DENORM_EN
    // Subnormals carry hidden bit 0 and the minimum exponent 1.
    assign a_zero = !(|ea) && !(|fa);
    assign b_zero = !(|eb) && !(|fb);
    assign ma     = {|ea, fa};
    assign mb     = {|eb, fb};
    assign eaf    = (|ea) ? ea : EXP_W'(1);
    assign ebf    = (|eb) ? eb : EXP_W'(1);
`else
    assign a_zero = !(|ea);
    assign b_zero = !(|eb);
    assign ma     = {1'b1, fa};
    assign mb     = {1'b1, fb};
    assign eaf    = ea;
    assign ebf    = eb;
`endif

    always_comb begin
        kind_c = K_NORM;
        inv_c  = 1'b0;
        if (a_nan || b_nan) begin
            kind_c = K_NAN;
        end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
            kind_c = K_NAN;
            inv_c  = 1'b1;
        end else if (a_zero || b_zero) begin
            kind_c = K_ZERO;
        end else if (a_inf || b_inf) begin
            kind_c = K_INF;
        end
    end

    logic                 s1_sign, s1_inv;
    logic signed [EW-1:0] s1_exp;
    logic [MAN_W:0]       s1_ma, s1_mb;
    logic [1:0]           s1_kind;
    logic [TAG_W-1:0]     s1_tag;

    always_ff @(posedge clk) begin
        if (ready1 && bus.in_valid) begin
            s1_sign <= sa ^ sb;
            s1_exp  <= {2'b00, eaf} + {2'b00, ebf} - EW'(BIAS);
            s1_ma   <= ma;
            s1_mb   <= mb;
            s1_kind <= kind_c;
            s1_inv  <= inv_c;
            s1_tag  <= bus.in_tag;
        end
    end

    // ------------------------------------------------------------------ stage 2
    logic                 s2_sign, s2_inv;
    logic signed [EW-1:0] s2_exp;
    logic [P-1:0]         s2_prod;
    logic [1:0]           s2_kind;
    logic [TAG_W-1:0]     s2_tag;

    always_ff @(posedge clk) begin
        if (ready2 && v1) begin
            s2_sign <= s1_sign;
            s2_exp  <= s1_exp;
            s2_prod <= P'(s1_ma) * P'(s1_mb);
            s2_kind <= s1_kind;
            s2_inv  <= s1_inv;
            s2_tag  <= s1_tag;
        end
    end

    // ------------------------------------------------------------------ stage 3
    logic [P-1:0]         norm;
    logic signed [EW-1:0] exp_adj, exp_r;
    logic [XW-1:0]        ext;
    logic                 tiny;
    logic [MAN_W:0]       kept;
    logic                 guard, sticky, inc;
    logic [MAN_W+1:0]     rounded;
    logic [MAN_W-1:0]     frac_r;
    logic [W-1:0]         res_p;
    logic [2:0]           res_f;

`ifdef FP_MULT_DENORM_EN
    localparam int LZW = $clog2(P + 1);
    logic [LZW-1:0] lzc;
    logic           found;
    logic [EW-1:0]  sh;

    always_comb begin
        lzc   = '0;
        found = 1'b0;
        for (int i = P - 1; i >= 0; i--) begin
            if (!found) begin
                if (s2_prod[i]) found = 1'b1;
                else            lzc   = lzc + LZW'(1);
            end
        end
        // Leading one lands on the top bit; exponent compensates for the shift.
        norm    = s2_prod << lzc;
        exp_adj = s2_exp + EW'(1) - EW'(lzc);
        tiny    = (exp_adj <= EXP_ZERO);
        sh      = '0;
        if (tiny) begin
            sh = EW'(1) - exp_adj;
            if (sh > EW'(MAN_W + 3)) sh = EW'(MAN_W + 3);
        end
        ext = {norm, {(MAN_W+3){1'b0}}} >> sh;
    end
`else
    always_comb begin
        tiny = 1'b0;
        if (s2_prod[P-1]) begin
            norm    = s2_prod;
            exp_adj = s2_exp + EW'(1);
        end else begin
            norm    = s2_prod << 1;
            exp_adj = s2_exp;
        end
        ext = {norm, {(MAN_W+3){1'b0}}};
    end
`endif

    always_comb begin
        kept    = ext[XW-1 -: MAN_W+1];
        guard   = ext[XW-2-MAN_W];
        sticky  = |ext[XW-3-MAN_W:0];
        inc     = guard && (sticky || kept[0]);
        rounded = {1'b0, kept} + (MAN_W+2)'(inc);
        exp_r   = exp_adj + EW'(rounded[MAN_W+1]);
        frac_r  = rounded[MAN_W+1] ? rounded[MAN_W:1] : rounded[MAN_W-1:0];
        res_p   = '0;
        res_f   = '0;
        case (s2_kind)
            K_NAN: begin
                res_p = QNAN;
                res_f = {s2_inv, 2'b00};
            end
            K_ZERO: res_p = {s2_sign, {(W-1){1'b0}}};
            K_INF:  res_p = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            default: begin
                if (tiny) begin
                    // A carry into the hidden position promotes to the smallest normal.
                    res_p    = {s2_sign, {(EXP_W-1){1'b0}}, rounded[MAN_W:0]};
                    res_f[0] = guard || sticky;
                end else if (exp_r >= EXP_MAX) begin
                    res_p    = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    res_f[1] = 1'b1;
                end else if (exp_r <= EXP_ZERO) begin
                    res_p    = {s2_sign, {(W-1){1'b0}}};
                    res_f[0] = 1'b1;
                end else begin
                    res_p = {s2_sign, exp_r[EXP_W-1:0], frac_r};
                end
            end
        endcase
    end

    logic [W-1:0]     p3;
    logic [TAG_W-1:0] tag3;
    logic [2:0]       flags3;

    always_ff @(posedge clk) begin
        if (rst) begin
            p3     <= '0;
            tag3   <= '0;
            flags3 <= '0;
        end else if (ready3 && v2) begin
            p3     <= res_p;
            tag3   <= s2_tag;
            flags3 <= res_f;
        end
    end

    assign bus.out_valid = v3;
    assign bus.out_p     = p3;
    assign bus.out_tag   = tag3;
    assign bus.out_flags = flags3;

endmodule
`default_nettype wire

// File: tb/tb_fp_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_mult_pipe
// Brief    : Directed self-checking bench for fp_mult_pipe (BF16 defaults).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_mult_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fp_mult_pipe_if #(.EXP_W(8), .MAN_W(7), .TAG_W(4)) bus ();

    fp_mult_pipe #(.EXP_W(8), .MAN_W(7), .TAG_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one operand pair with out_ready high and waits for its result.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] tag,
                          output logic acc, output int lat, output logic [15:0] p,
                          output logic [3:0] tag_o, output logic [2:0] flags);
        bus.in_valid  = 1'b1;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_tag    = tag;
        bus.out_ready = 1'b1;
        #1;
        acc = bus.in_ready;
        tick();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        p     = bus.out_p;
        tag_o = bus.out_tag;
        flags = bus.out_flags;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        n_checks++;
        if (bus.out_p !== 16'h0000) begin n_fail++; $display("FAIL reset_out_p: got %h expected 0000", bus.out_p); end
        n_checks++;
        if (bus.out_tag !== 4'h0 || bus.out_flags !== 3'b000) begin
            n_fail++; $display("FAIL reset_tag_flags: got %h/%b expected 0/000", bus.out_tag, bus.out_flags);
        end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        tick();
    endtask

    task automatic test_basic();
        logic acc; int lat; logic [15:0] p; logic [3:0] t; logic [2:0] f;
        run_op(16'h3FC0, 16'h3FC0, 4'hA, acc, lat, p, t, f);
        n_checks++;
        if (acc !== 1'b1) begin n_fail++; $display("FAIL basic_accept: got %b expected 1", acc); end
        n_checks++;
        if (lat != 3) begin n_fail++; $display("FAIL basic_latency: got %0d expected 3", lat); end
        n_checks++;
        if (p !== 16'h4010 || f !== 3'b000 || t !== 4'hA) begin
            n_fail++; $display("FAIL basic_result: got %h/%b/%h expected 4010/000/a", p, f, t);
        end
        run_op(16'hBFC0, 16'h3FC0, 4'h3, acc, lat, p, t, f);
        n_checks++;
        if (p !== 16'hC010 || f !== 3'b000) begin n_fail++; $display("FAIL basic_neg: got %h/%b expected c010/000", p, f); end
    endtask

    task automatic test_rounding();
        logic acc; int lat; logic [15:0] p; logic [3:0] t; logic [2:0] f;
        run_op(16'h3F81, 16'h3F81, 4'h1, acc, lat, p, t, f);
        n_checks++;
        if (p !== 16'h3F82 || f !== 3'b000) begin n_fail++; $display("FAIL rne_below_half: got %h/%b expected 3f82/000", p, f); end
        run_op(16'h3F81, 16'h3FC0, 4'h2, acc, lat, p, t, f);
        n_checks++;
        if (p !== 16'h3FC2 || f !== 3'b000) begin n_fail++; $display("FAIL rne_tie_even: got %h/%b expected 3fc2/000", p, f); end
    endtask

    task automatic test_specials();
        logic acc; int lat; logic [15:0] p; logic [3:0] t; logic [2:0] f;
        run_op(16'h7F80, 16'h0000, 4'h4, acc, lat, p, t, f);
        n_checks++;
        if (p !== 16'h7FC0 || f !== 3'b100) begin n_fail++; $display("FAIL inf_x_zero: got %h/%b expected 7fc0/100", p, f); end
        run_op(16'h7FC1, 16'h3F80, 4'h5, acc, lat, p, t, f);
        n_checks++;
        if (p !== 16'h7FC0 || f !== 3'b000) begin n_fail++; $display("FAIL nan_in: got %h/%b expected 7fc0/000", p, f); end
        run_op(16'h7F7F, 16'h4000, 4'h6, acc, lat, p, t, f);
        n_checks++;
        if (p !== 16'h7F80 || f !== 3'b010) begin n_fail++; $display("FAIL overflow: got %h/%b expected 7f80/010", p, f); end
        run_op(16'h8000, 16'h3F80, 4'h7, acc, lat, p, t, f);
        n_checks++;
        if (p !== 16'h8000 || f !== 3'b000) begin n_fail++; $display("FAIL signed_zero: got %h/%b expected 8000/000", p, f); end
        run_op(16'h7F80, 16'hC000, 4'h8, acc, lat, p, t, f);
        n_checks++;
        if (p !== 16'hFF80 || f !== 3'b000) begin n_fail++; $display("FAIL signed_inf: got %h/%b expected ff80/000", p, f); end
    endtask

    task automatic test_underflow();
        logic acc; int lat; logic [15:0] p; logic [3:0] t; logic [2:0] f;
        logic [15:0] exp_p1, exp_p2;
        logic [2:0]  exp_f1;
`ifdef FP_MULT_DENORM_EN
        exp_p1 = 16'h0040; exp_f1 = 3'b000; exp_p2 = 16'h0001;
`else
        exp_p1 = 16'h0000; exp_f1 = 3'b001; exp_p2 = 16'h0000;
`endif
        run_op(16'h0080, 16'h3F00, 4'h9, acc, lat, p, t, f);
        n_checks++;
        if (p !== exp_p1 || f !== exp_f1) begin
            n_fail++; $display("FAIL underflow_min_norm_half: got %h/%b expected %h/%b", p, f, exp_p1, exp_f1);
        end
        run_op(16'h0001, 16'h3F80, 4'hB, acc, lat, p, t, f);
        n_checks++;
        if (p !== exp_p2 || f !== 3'b000) begin
            n_fail++; $display("FAIL subnormal_input: got %h/%b expected %h/000", p, f, exp_p2);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] va [8];
        logic [15:0] vb [8];
        logic [15:0] vp [8];
        logic [2:0]  vf [8];
        int  sent, got, cyc;
        logic stall_seen_ready;
        va = '{16'h3FC0, 16'h3F81, 16'h3F81, 16'h4000, 16'hBF80, 16'h3F80, 16'h7F80, 16'h4040};
        vb = '{16'h3FC0, 16'h3F81, 16'h3FC0, 16'h4000, 16'h4040, 16'h3F80, 16'h0000, 16'h4040};
        vp = '{16'h4010, 16'h3F82, 16'h3FC2, 16'h4080, 16'hC040, 16'h3F80, 16'h7FC0, 16'h4110};
        vf = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000};
        sent = 0; got = 0; cyc = 0;
        stall_seen_ready = 1'b0;
        while (got < 8 && cyc < 60) begin
            bus.in_valid  = (sent < 8);
            bus.in_a      = va[sent % 8];
            bus.in_b      = vb[sent % 8];
            bus.in_tag    = 4'(sent + 5);
            bus.out_ready = !(cyc >= 4 && cyc <= 7);
            #1;
            if (cyc >= 4 && cyc <= 7 && bus.in_ready) stall_seen_ready = 1'b1;
            if (cyc == 3) begin
                n_checks++;
                if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_before_stall: got %b expected 1", bus.in_ready); end
            end
            if (bus.out_valid && bus.out_ready) begin
                n_checks++;
                if (bus.out_p !== vp[got] || bus.out_flags !== vf[got] || bus.out_tag !== 4'(got + 5)) begin
                    n_fail++;
                    $display("FAIL b2b_item%0d: got %h/%b/%h expected %h/%b/%h", got, bus.out_p, bus.out_flags,
                             bus.out_tag, vp[got], vf[got], 4'(got + 5));
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
            tick();
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n_checks++;
        if (stall_seen_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_ready: got in_ready 1 while full expected 0"); end
        n_checks++;
        if (got != 8 || sent != 8) begin n_fail++; $display("FAIL b2b_count: got %0d out/%0d in expected 8/8", got, sent); end
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_no_dup: got out_valid %b expected 0", bus.out_valid); end
        tick();
    endtask

    task automatic test_reset_midflight();
        logic acc; int lat; logic [15:0] p; logic [3:0] t; logic [2:0] f;
        logic leaked;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_a = 16'h4000; bus.in_b = 16'h4000; bus.in_tag = 4'hC;
        tick();
        bus.in_a = 16'h3FC0; bus.in_b = 16'h3FC0; bus.in_tag = 4'hD;
        tick();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_in_ready: got %b expected 1", bus.in_ready); end
        leaked = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (bus.out_valid) leaked = 1'b1;
            tick();
        end
        n_checks++;
        if (leaked !== 1'b0) begin n_fail++; $display("FAIL rst_mid_discard: got out_valid 1 expected 0"); end
        run_op(16'h4040, 16'h4040, 4'hE, acc, lat, p, t, f);
        n_checks++;
        if (lat != 3 || p !== 16'h4110 || t !== 4'hE || f !== 3'b000) begin
            n_fail++; $display("FAIL rst_mid_next_op: got lat %0d %h/%h/%b expected 3 4110/e/000", lat, p, t, f);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_rounding();
        test_specials();
        test_underflow();
        test_back_to_back();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
